muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with a {hi,lo} result.
// Multiply uses shift-add and divide uses restoring division, one bit per cycle.
// With MUL_FAST set, a multiply finishes in one cycle instead.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    input  logic               hold,
    output logic               stall,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} StateT;

    StateT state, nextState;

    logic             isDiv;
    logic             negHi;
    logic             negLo;
    logic             divZero;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] operand;

    logic               inSigned;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [2*WIDTH-1:0] fastMag;
    logic [2*WIDTH-1:0] fastResult;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic [WIDTH-1:0]   stepHi;
    logic [WIDTH-1:0]   stepLo;
    logic [2*WIDTH-1:0] calcResult;

    // Applies the latched signs to the magnitude results. A product is negated
    // as one double-width value. A divide negates each half separately. A
    // zero divisor forces the quotient to all ones.
    function automatic logic [2*WIDTH-1:0] packResult(
        input logic             divOp,
        input logic             nHi,
        input logic             nLo,
        input logic             zero,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo
    );
        logic [2*WIDTH-1:0] mag;
        logic [WIDTH-1:0]   rHi;
        logic [WIDTH-1:0]   rLo;
        mag = {hi, lo};
        rHi = nHi ? -hi : hi;
        rLo = zero ? '1 : (nLo ? -lo : lo);
        if (divOp) begin
            return {rHi, rLo};
        end
        return nHi ? -mag : mag;
    endfunction

    // Converts the incoming operands to magnitudes and computes the one-cycle product.
    always_comb begin
        inSigned   = ~op[0];
        aNeg       = inSigned & a[WIDTH-1];
        bNeg       = inSigned & b[WIDTH-1];
        aMag       = aNeg ? -a : a;
        bMag       = bNeg ? -b : b;
        fastMag    = {{WIDTH{1'b0}}, aMag} * {{WIDTH{1'b0}}, bMag};
        fastResult = packResult(1'b0, aNeg ^ bNeg, aNeg ^ bNeg, 1'b0,
                                fastMag[2*WIDTH-1:WIDTH], fastMag[WIDTH-1:0]);
    end

    // Computes one iteration step. A multiply adds into hi and then shifts right.
    // A divide shifts left, does a trial subtraction and sets the quotient bit.
    always_comb begin
        mulSum   = '0;
        divShift = '0;
        divDiff  = '0;
        stepHi   = accHi;
        stepLo   = accLo;
        if (isDiv) begin
            divShift = {accHi, accLo[WIDTH-1]};
            divDiff  = divShift - {1'b0, operand};
            stepHi   = divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
            stepLo   = {accLo[WIDTH-2:0], ~divDiff[WIDTH]};
        end else begin
            mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
        calcResult = packResult(isDiv, negHi, negLo, divZero, stepHi, stepLo);
    end

    // Selects the next state. A flush always returns to IDLE, and DONE ignores start.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = (MUL_FAST && !op[1]) ? DONE : CALC;
            CALC: if (counter == LAST) nextState = DONE;
            DONE: if (!hold) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (flush) nextState = IDLE;
    end

    // Drives the handshake outputs. Stall is gated by reset so that it is quiet while reset is held.
    always_comb begin
        stall = rst & (((state == IDLE) & start & ~flush) | (state == CALC));
        done  = (state == DONE);
    end

    // Holds the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Latches operands on accept, iterates in CALC and loads the result on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            isDiv   <= 1'b0;
            negHi   <= 1'b0;
            negLo   <= 1'b0;
            divZero <= 1'b0;
            counter <= '0;
            accHi   <= '0;
            accLo   <= '0;
            operand <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        isDiv   <= op[1];
                        negHi   <= op[1] ? aNeg : (aNeg ^ bNeg);
                        negLo   <= aNeg ^ bNeg;
                        divZero <= op[1] & (b == '0);
                        counter <= '0;
                        accHi   <= '0;
                        accLo   <= op[1] ? aMag : bMag;
                        operand <= op[1] ? bMag : aMag;
                        if (MUL_FAST && !op[1]) result <= fastResult;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        accHi   <= stepHi;
                        accLo   <= stepLo;
                        counter <= counter + 1'b1;
                        if (counter == LAST) result <= calcResult;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
